// File: rtl/nios2_system_irq_pkg.sv
// Register map and vector layout shared by the Nios II interrupt aggregator.
package nios2_system_irq_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd5;

  localparam int VECTOR_VALID_BIT = 15;
  localparam int VECTOR_IDX_W     = 4;
  localparam int NUM_IRQ_MAX      = 15;

  function automatic logic [DATA_W-1:0] make_vector(input logic valid,
                                                    input logic [VECTOR_IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    v[VECTOR_VALID_BIT] = valid;
    v[VECTOR_IDX_W-1:0] = idx;
    return v;
  endfunction

endpackage

// File: rtl/nios2_system_irq_sync.sv
// W-bit, STAGES-deep flop synchroniser; STAGES = 0 passes the input straight through.
module nios2_system_irq_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_sync
      logic [W-1:0] stage_q [STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/nios2_system_irq_ctrl.sv
// Interrupt aggregator: synchronise, latch (edge or level), mask and combine peripheral irqs
// into one registered CPU irq, with a 16-bit Avalon-MM register slave.
module nios2_system_irq_ctrl
  import nios2_system_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [ADDR_W-1:0]  address,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] irq_sync;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] status;
  logic [NUM_IRQ-1:0] irq_event;
  logic [NUM_IRQ-1:0] wdata, w1c, force_set;
  logic               wr_en;
  logic               irq_out_q;
  logic [DATA_W-1:0]  readdata_q, rd_mux;
  logic [VECTOR_IDX_W-1:0] vec_idx;
  logic               unused_wdata;

  nios2_system_irq_sync #(
    .W      (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (irq_in),
    .q_o     (irq_sync)
  );

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata[DATA_W-1:NUM_IRQ];
  assign w1c          = (wr_en && address == ADDR_PENDING) ? wdata : '0;
  assign force_set    = (wr_en && address == ADDR_FORCE)   ? wdata : '0;
  assign irq_event    = irq_sync & ~irq_prev_q;
  assign status       = pending_q & mask_q;

  // Set terms are OR-ed after the clear so an event or force beats a same-cycle W1C.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      assign pending_d[gi] = edge_q[gi]
                           ? (irq_event[gi] | force_set[gi] | (pending_q[gi] & ~w1c[gi]))
                           : irq_sync[gi];
    end
  endgenerate

  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (status[i]) vec_idx = VECTOR_IDX_W'(i);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux[NUM_IRQ-1:0] = status;
      ADDR_PENDING: rd_mux[NUM_IRQ-1:0] = pending_q;
      ADDR_MASK:    rd_mux[NUM_IRQ-1:0] = mask_q;
      ADDR_EDGE:    rd_mux[NUM_IRQ-1:0] = edge_q;
      ADDR_VECTOR:  rd_mux = make_vector(|status, vec_idx);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      irq_out_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      irq_prev_q <= irq_sync;
      pending_q  <= pending_d;
      irq_out_q  <= |status;
      readdata_q <= rd_mux;
      if (wr_en && address == ADDR_MASK) mask_q <= wdata;
      if (wr_en && address == ADDR_EDGE) edge_q <= wdata;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_nios2_system_irq_ctrl.sv
// Scoreboard bench for nios2_system_irq_ctrl: directed scenarios plus random bus/irq traffic.
module tb_nios2_system_irq_ctrl;

  localparam int NUM_IRQ     = 8;
  localparam int SYNC_STAGES = 2;
  localparam logic [15:0] ALL = 16'((1 << NUM_IRQ) - 1);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               chipselect = 1'b0;
  logic [2:0]         address = '0;
  logic               write_n = 1'b1;
  logic [15:0]        writedata = '0;
  logic [15:0]        readdata;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               irq_out;

  always #5 clk = ~clk;

  nios2_system_irq_ctrl #(
    .NUM_IRQ     (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  bit      irq_q[$];

  // Reference model: register contents plus a queue of raw samples standing in for the synchroniser.
  logic [15:0] m_pend = '0, m_mask = '0, m_edge = '0, m_prev = '0;
  logic [15:0] m_in_q[$];

  function automatic logic [15:0] m_read(input logic [2:0] a);
    logic [15:0] st;
    st = m_pend & m_mask;
    case (a)
      3'd0: return st;
      3'd1: return m_pend;
      3'd2: return m_mask;
      3'd3: return m_edge;
      3'd4: begin
        for (int i = 0; i < NUM_IRQ; i++) if (st[i]) return 16'h8000 | 16'(i);
        return 16'h0000;
      end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_clear();
    m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0;
    m_in_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_in_q.push_back(16'h0);
  endtask

  initial begin
    logic [15:0] sync_v, wd;
    bit wr;
    m_clear();
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_clear();
        irq_q.push_back(1'b0);
      end else begin
        if (chipselect && write_n) rd_q.push_back('{address, m_read(address)});
        irq_q.push_back(|(m_pend & m_mask));
        if (SYNC_STAGES == 0) begin
          sync_v = 16'(irq_in);
        end else begin
          sync_v = m_in_q.pop_back();
          m_in_q.push_front(16'(irq_in));
        end
        wr = chipselect && !write_n;
        wd = writedata & ALL;
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (m_edge[i]) begin
            if ((sync_v[i] && !m_prev[i]) || (wr && address == 3'd5 && wd[i])) m_pend[i] = 1'b1;
            else if (wr && address == 3'd1 && wd[i]) m_pend[i] = 1'b0;
          end else begin
            m_pend[i] = sync_v[i];
          end
        end
        m_prev = sync_v;
        if (wr && address == 3'd2) m_mask = wd;
        if (wr && address == 3'd3) m_edge = wd;
      end
    end
  end

  // Monitor: irq_out every cycle, readdata one cycle after each read strobe.
  initial begin
    bit      rv, ei;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      rv = chipselect && write_n && reset_n;
      @(negedge clk);
      vectors++;
      if (irq_q.size() == 0) begin
        miscompares++;
        $display("FAIL irq_out: no expectation queued, got %0b", irq_out);
      end else begin
        ei = irq_q.pop_front();
        if (irq_out !== ei) begin
          miscompares++;
          $display("FAIL irq_out @%0t: got %0b expected %0b", $time, irq_out, ei);
        end
      end
      if (rv) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL read: no expectation queued, got %h", readdata);
        end else begin
          e = rd_q.pop_front();
          if (readdata !== e.data) begin
            miscompares++;
            $display("FAIL read addr %0d @%0t: got %h expected %h", e.addr, $time, readdata, e.data);
          end else begin
            $display("read addr %0d -> %h", e.addr, readdata);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("%s -> %h", name, act);
    end
  endtask

  // Reset edges land 2 time units past the negedge so they never race the monitor's sampling.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    irq_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int op;
    tick(3);
    reset_n = 1'b1;
    check("reset readdata", readdata, 16'h0000);
    check("reset irq_out", 16'(irq_out), 16'h0000);

    // Edge source, irq latency and W1C release.
    bus_write(3'd2, 16'h0001);
    bus_write(3'd3, 16'h0001);
    irq_in[0] = 1'b1; tick(4); irq_in[0] = 1'b0;
    bus_read(3'd4);
    tick(2);
    bus_write(3'd1, 16'h0001);
    tick(3);
    bus_read(3'd1);

    // Level source ignores W1C and follows the input.
    do_reset();
    bus_write(3'd2, 16'h0008);
    irq_in[3] = 1'b1; tick(4);
    bus_read(3'd0);
    bus_write(3'd1, 16'h0008);
    tick(2);
    bus_read(3'd0);
    irq_in[3] = 1'b0; tick(5);

    // Masked edge event is retained and fires when unmasked.
    do_reset();
    bus_write(3'd3, 16'h00FF);
    irq_in[5] = 1'b1; tick(4);
    bus_read(3'd1);
    bus_write(3'd2, 16'h0020);
    tick(3);
    bus_read(3'd4);
    irq_in = '0;

    // Edge event and W1C hit the same clock edge.
    do_reset();
    bus_write(3'd3, 16'h00FF);
    bus_write(3'd2, 16'h00FF);
    irq_in[2] = 1'b1; tick(2);
    bus_write(3'd1, 16'h0004);
    bus_read(3'd1);
    irq_in = '0;

    // Priority encoder walks up as lower bits clear.
    do_reset();
    bus_write(3'd3, 16'h00FF);
    bus_write(3'd5, 16'h0014);
    bus_write(3'd2, 16'h00FF);
    bus_read(3'd4);
    bus_write(3'd1, 16'h0004);
    bus_read(3'd4);
    bus_write(3'd1, 16'h0010);
    bus_read(3'd4);

    // FORCE only on edge bits, write-only/reserved reads, then reset mid-operation.
    do_reset();
    bus_write(3'd3, 16'h0001);
    bus_write(3'd5, 16'h0081);
    bus_write(3'd2, 16'h0001);
    bus_read(3'd1);
    bus_read(3'd5);
    bus_read(3'd6);
    bus_read(3'd7);
    tick(1);
    bus_read(3'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset readdata", readdata, 16'h0000);
    check("async reset irq_out", 16'(irq_out), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd1);
    bus_read(3'd2);

    // Random traffic.
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      if (it % 2 == 0) irq_in = NUM_IRQ'($urandom);
      op = $urandom_range(0, 9);
      if (op < 4) bus_read(3'($urandom_range(0, 7)));
      else if (op < 7) bus_write(3'($urandom_range(0, 7)), 16'($urandom));
      else tick(1);
    end
    irq_in = '0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
